// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: 32-iteration shift-add / restoring-divide engine owning HI/LO.
// Optional signed MULT/DIV ops enabled by defining MULDIV_SIGNED_EN.
module hilo_muldiv_unit #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d, b_q, b_d, m_q, m_d, x_q, x_d, hi_q, hi_d, lo_q, lo_d;
   logic        div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;
   logic        legal, is_div, sgn, ge;
   logic [31:0] ax, ay;
   logic [32:0] sum, shl, trial;
   logic [63:0] prod;

   always_comb begin
`ifdef MULDIV_SIGNED_EN
      legal = op == 4'b0011 || op == 4'b0100 || op == 4'b1101 || op == 4'b1110;
      sgn   = op == 4'b1101 || op == 4'b1110;
`else
      legal = op == 4'b0011 || op == 4'b0100;
      sgn   = 1'b0;
`endif
      is_div = op == 4'b0100 || op == 4'b1110;
      ax     = (sgn && x[31]) ? -x : x;
      ay     = (sgn && y[31]) ? -y : y;
   end

   // a/b hold {acc, multiplier} for multiply and {rem, quot} for divide
   always_comb begin
      sum   = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : 33'd0);
      shl   = {a_q, b_q[31]};
      ge    = shl >= {1'b0, m_q};
      trial = shl - {1'b0, m_q};
      prod  = neg_q ? -{a_q, b_q} : {a_q, b_q};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      x_d     = x_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: if (start && legal) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = is_div ? ax : ay;
            m_d     = is_div ? ay : ax;
            x_d     = x;
            div_d   = is_div;
            neg_d   = sgn && (x[31] ^ y[31]);
            rneg_d  = sgn && x[31];
         end
         RUN: if (cnt_q == 6'(ITER)) begin
            state_d = DONE;
            dbz_d   = div_q && m_q == '0;
            lo_d    = !div_q ? prod[31:0] : m_q == '0 ? '1 : neg_q ? -b_q : b_q;
            hi_d    = !div_q ? prod[63:32] : m_q == '0 ? x_q : rneg_q ? -a_q : a_q;
         end else begin
            cnt_d = cnt_q + 6'd1;
            a_d   = div_q ? (ge ? trial[31:0] : shl[31:0]) : sum[32:1];
            b_d   = div_q ? {b_q[30:0], ge} : {sum[0], b_q[31:1]};
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         x_q     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         x_q     <= x_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = state_q != IDLE;
   assign done        = state_q == DONE;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = done && dbz_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench with a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] x = '0, y = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;
   int          checks = 0, errors = 0;
   logic [64:0] sbq[$];
   logic [31:0] exp_hi = '0, exp_lo = '0;

   hilo_muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit legal_op(input logic [3:0] o);
`ifdef MULDIV_SIGNED_EN
      return o == 4'b0011 || o == 4'b0100 || o == 4'b1101 || o == 4'b1110;
`else
      return o == 4'b0011 || o == 4'b0100;
`endif
   endfunction

   function automatic logic [64:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint     p;
      logic [63:0] up;
      int         q, r;
      up = {32'd0, a} * {32'd0, b};
      case (o)
         4'b0011: return {1'b0, up};
         4'b0100: return b == 0 ? {1'b1, a, 32'hFFFF_FFFF} : {1'b0, a % b, a / b};
         4'b1101: begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {1'b0, 64'(p)};
         end
         default: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {1'b0, 32'(r), 32'(q)};
         end
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no done (hi=%h lo=%h)", hi, lo);
            end else begin
               logic [64:0] e;
               e = sbq.pop_front();
               chk("result_hilo", {hi, lo}, e[63:0]);
               chk("result_dbz", 64'(div_by_zero), 64'(e[64]));
            end
         end else chk("dbz_outside_done", 64'(div_by_zero), 64'd0);
      end
   end

   // Called at a negedge; returns at the negedge of the first IDLE cycle afterwards
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int glitch);
      int  n, bc;
      bit  seen;
      logic [64:0] e;
      start = 1'b1;
      op = o;
      x = a;
      y = b;
      if (legal_op(o)) begin
         e = model(o, a, b);
         sbq.push_back(e);
         exp_hi = e[63:32];
         exp_lo = e[31:0];
      end
      @(posedge clk);
      #1 start = 1'b0;
      x = $urandom;
      y = $urandom;
      op = legal_op(o) ? 4'b0100 : o;
      bc = 0;
      seen = 1'b0;
      n = 0;
      while (n < 40 && !seen) begin
         @(negedge clk);
         n++;
         start = (glitch != 0 && n == glitch);
         bc += busy ? 1 : 0;
         seen = done;
      end
      start = 1'b0;
      if (legal_op(o)) begin
         chk("done_latency", 64'(n), 64'd34);
         chk("busy_cycles", 64'(bc), 64'd34);
         @(negedge clk);
         chk("idle_after_done", 64'(busy), 64'd0);
      end else begin
         chk("illegal_busy", 64'(bc), 64'd0);
         chk("illegal_hilo", {hi, lo}, {exp_hi, exp_lo});
      end
   endtask

   initial begin
      #1;
      chk("reset_state", {27'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(4'b0100, 32'd100, 32'd7, 12);
      chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
      repeat (40) @(negedge clk);
      chk("no_second_done", 64'(sbq.size()), 64'd0);
      run_op(4'b0100, 32'h1234_5678, 32'd0, 0);
      chk("divu_zero", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});
      // reset mid-run of a multiply
      start = 1'b1;
      op = 4'b0011;
      x = 32'hDEAD_BEEF;
      y = 32'h1234_5678;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_state", {30'd0, busy, done, hi, lo}, 64'd0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      run_op(4'b0100, 32'd9, 32'd3, 0);
      chk("divu_9_3", {hi, lo}, {32'd0, 32'd3});
      run_op(4'b0101, 32'd5, 32'd6, 0);
      run_op(4'b1101, 32'hFFFF_FFFD, 32'd5, 0);
`ifdef MULDIV_SIGNED_EN
      chk("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(4'b1110, 32'hFFFF_FFF9, 32'd2, 0);
      chk("div_neg7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("div_min_neg1", {hi, lo}, {32'd0, 32'h8000_0000});
      run_op(4'b1110, 32'hFFFF_FF00, 32'd0, 0);
`endif
      for (int i = 0; i < 24; i++) begin
         logic [3:0]  o;
         logic [31:0] a, b;
`ifdef MULDIV_SIGNED_EN
         case ($urandom_range(0, 3))
            0: o = 4'b0011;
            1: o = 4'b0100;
            2: o = 4'b1101;
            default: o = 4'b1110;
         endcase
`else
         o = $urandom_range(0, 1) ? 4'b0011 : 4'b0100;
`endif
         a = $urandom;
         b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
         if ($urandom_range(0, 5) == 0) o = 4'($urandom_range(5, 12));
         run_op(o, a, b, $urandom_range(0, 1) ? 0 : 5);
      end
      repeat (40) @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
